// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative RV64M multiply/divide unit for the execute stage.
// Multiplies use radix-2 shift-add and divides use restoring division, both on
// operand magnitudes with a sign fix-up when the result is registered.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle through
// a combinational multiplier; divides stay iterative.
module execute_muldiv #(
    parameter int XLEN     = 64,
    parameter int WORD_LEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [2:0]      funct3,
    input  logic            is_word,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    input  logic            ok_to_proceed_overall,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            ok_to_proceed
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       count;
    logic [XLEN-1:0]     x;      // multiplier (shifts right) / dividend-quotient (shifts left)
    logic [2*XLEN-1:0]   y;      // multiplicand (shifts left) / divisor in low half
    logic [2*XLEN-1:0]   acc;    // product / partial remainder in low half
    logic                op_div, op_rem, op_hi, word_r, neg_q, neg_r;

    // Sign-extend the low word of a value when operating on *W ops
    function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-WORD_LEN){v[WORD_LEN-1]}}, v[WORD_LEN-1:0]} : v;
    endfunction

    // Operand decode: signedness, magnitudes and divide special cases
    logic                is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [1:0]          f3_lo;
    logic [XLEN-1:0]     a_ext, b_ext, a_mag, b_mag, min_val, spec_res;

    always_comb begin
        is_div   = funct3[2];
        // *W with a high-multiply funct3 is treated as MULW
        f3_lo    = (is_word && !funct3[2]) ? 2'b00 : funct3[1:0];
        a_signed = is_div ? ~f3_lo[0] : (f3_lo != 2'b11);
        b_signed = is_div ? ~f3_lo[0] : ~f3_lo[1];
        a_ext    = is_word ? {{(XLEN-WORD_LEN){a_signed & op_a[WORD_LEN-1]}}, op_a[WORD_LEN-1:0]} : op_a;
        b_ext    = is_word ? {{(XLEN-WORD_LEN){b_signed & op_b[WORD_LEN-1]}}, op_b[WORD_LEN-1:0]} : op_b;
        a_neg    = a_signed & a_ext[XLEN-1];
        b_neg    = b_signed & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        min_val  = is_word ? {{(XLEN-WORD_LEN+1){1'b1}}, {(WORD_LEN-1){1'b0}}}
                           : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        div_ovf  = ~f3_lo[0] & (a_ext == min_val) & (b_ext == '1);
        if (div_zero)
            spec_res = wfix(is_word, f3_lo[1] ? a_ext : '1);
        else
            spec_res = wfix(is_word, f3_lo[1] ? '0 : a_ext);
    end

    // Single-cycle multiply path (only present with the fast-multiply build)
    logic            fast_mul;
    logic [XLEN-1:0] fast_res;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    always_comb begin
        fast_mul  = ~is_div;
        fast_prod = a_mag * b_mag;
        if (a_neg ^ b_neg)
            fast_prod = -fast_prod;
        fast_res  = wfix(is_word, (f3_lo != 2'b00) ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0]);
    end
`else
    always_comb begin
        fast_mul = 1'b0;
        fast_res = '0;
    end
`endif

    // One radix-2 iteration plus the signed result formed from its outputs
    logic [2*XLEN-1:0] mul_acc_nx, prod, acc_nx, y_nx;
    logic [XLEN:0]     div_sh, div_rem_nx;
    logic [XLEN+1:0]   div_diff;
    logic              qbit;
    logic [XLEN-1:0]   div_x_nx, x_nx, quo, rem, mul_res, fin_res;

    always_comb begin
        mul_acc_nx = x[0] ? acc + y : acc;
        div_sh     = {acc[XLEN-1:0], x[XLEN-1]};
        div_diff   = {1'b0, div_sh} - {2'b00, y[XLEN-1:0]};
        qbit       = ~div_diff[XLEN+1];
        div_rem_nx = qbit ? div_diff[XLEN:0] : div_sh;
        div_x_nx   = {x[XLEN-2:0], qbit};
        acc_nx     = op_div ? {{(XLEN-1){1'b0}}, div_rem_nx} : mul_acc_nx;
        x_nx       = op_div ? div_x_nx : (x >> 1);
        y_nx       = op_div ? y : (y << 1);
        prod       = neg_q ? -mul_acc_nx : mul_acc_nx;
        mul_res    = op_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        quo        = neg_q ? -div_x_nx : div_x_nx;
        rem        = neg_r ? -div_rem_nx[XLEN-1:0] : div_rem_nx[XLEN-1:0];
        fin_res    = wfix(word_r, op_div ? (op_rem ? rem : quo) : mul_res);
    end

    assign ok_to_proceed = ~in_valid | done;

    // Control FSM with registered result/done/busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            count  <= '0;
            x      <= '0;
            y      <= '0;
            acc    <= '0;
            op_div <= 1'b0;
            op_rem <= 1'b0;
            op_hi  <= 1'b0;
            word_r <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_div <= is_div;
                    op_rem <= f3_lo[1];
                    op_hi  <= (f3_lo != 2'b00);
                    word_r <= is_word;
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    acc    <= '0;
                    if (is_div && (div_zero || div_ovf)) begin
                        result <= spec_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (fast_mul) begin
                        result <= fast_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        count <= is_word ? CW'(WORD_LEN) : CW'(XLEN);
                        if (is_div) begin
                            // word dividends are left-justified so the MSB feeds the remainder first
                            x <= is_word ? {a_mag[WORD_LEN-1:0], {(XLEN-WORD_LEN){1'b0}}} : a_mag;
                            y <= {{XLEN{1'b0}}, b_mag};
                        end else begin
                            x <= b_mag;
                            y <= {{XLEN{1'b0}}, a_mag};
                        end
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_nx;
                    x     <= x_nx;
                    y     <= y_nx;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        result <= fin_res;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: if (ok_to_proceed_overall) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// tb_execute_muldiv: scoreboard bench for execute_muldiv. A driver issues ops
// and queues the reference result and latency; a monitor pops on each done.
module tb_execute_muldiv;

    logic        clk = 1'b0;
    logic        rst, in_valid, is_word, flush, ovr;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b, result;
    logic        done, busy, okp;

    always #5 clk = ~clk;

    execute_muldiv dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .funct3(funct3), .is_word(is_word),
        .op_a(op_a), .op_b(op_b), .flush(flush), .ok_to_proceed_overall(ovr),
        .result(result), .done(done), .busy(busy), .ok_to_proceed(okp)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, failures = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    logic [63:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // RV64M reference: plain arithmetic with the architectural special cases
    function automatic logic [63:0] ref_model(input logic [2:0] f, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] pa, pb, ps;
        logic [127:0]        pu;
        logic [63:0]         m64;
        logic [31:0]         m32, ua, ub;
        int                  sa, sb;
        longint              la, lb;
        ua = a[31:0]; ub = b[31:0]; sa = a[31:0]; sb = b[31:0];
        la = a; lb = b;
        if (w) begin
            case (f)
                3'd4: if (ub == 0) return '1;
                      else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sx32(ua);
                      else return sx32(32'(sa / sb));
                3'd5: if (ub == 0) return '1; else return sx32(ua / ub);
                3'd6: if (ub == 0) return sx32(ua);
                      else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return '0;
                      else return sx32(32'(sa % sb));
                3'd7: if (ub == 0) return sx32(ua); else return sx32(ua % ub);
                default: begin m32 = ua * ub; return sx32(m32); end
            endcase
        end
        case (f)
            3'd0: begin m64 = a * b; return m64; end
            3'd1: begin pa = $signed({{64{a[63]}}, a}); pb = $signed({{64{b[63]}}, b});
                        ps = pa * pb; return ps[127:64]; end
            3'd2: begin pa = $signed({{64{a[63]}}, a}); pb = $signed({64'b0, b});
                        ps = pa * pb; return ps[127:64]; end
            3'd3: begin pu = {64'b0, a} * {64'b0, b}; return pu[127:64]; end
            3'd4: if (b == 0) return '1;
                  else if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
                  else return 64'(la / lb);
            3'd5: if (b == 0) return '1; else return a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 64'h8000_0000_0000_0000 && b == '1) return '0;
                  else return 64'(la % lb);
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic bz, ov;
        bz = w ? (b[31:0] == 0) : (b == 0);
        ov = !f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (f[2] && (bz || ov)) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 8))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return 64'h8000_0000_0000_0000;
            4: return {32'h0, $urandom};
            5: return 64'($urandom_range(0, 20));
            6: return {32'hFFFF_FFFF, $urandom};
            7: return {$urandom, 32'h8000_0000};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: on each new done pop the oldest expectation and compare
    initial begin
        logic dq;
        exp_t e;
        dq = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) dq = 1'b0;
            else begin
                if (done && !dq) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_done actual=%h required=no_output", result);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, "_result"}, result, e.res);
                        chk({e.name, "_latency"}, 64'(cyc - accept_cyc), 64'(e.lat));
                    end
                end
                dq = done;
            end
        end
    end

    // Issue one op at the current negedge, wait for done, stall, then consume
    task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int stall, input string name);
        exp_t e;
        logic bad;
        int   n;
        e.res = ref_model(f, w, a, b);
        e.lat = ref_lat(f, w, a, b);
        e.name = name;
        funct3 = f; is_word = w; op_a = a; op_b = b; in_valid = 1'b1;
        accept_cyc = cyc;
        exp_q.push_back(e);
        #1;
        bad = (okp !== 1'b0);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
            if (okp !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            if (n > 200) begin
                checks++; failures++;
                $display("FAIL %s_timeout actual=%0d required=%0d", name, n, e.lat);
                break;
            end
            op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
            funct3 = 3'($urandom); is_word = 1'($urandom);
        end
        chk({name, "_stall_handshake"}, 64'(bad), 64'(0));
        for (int k = 0; k < stall; k++) begin
            ovr = 1'b0;
            @(negedge clk);
            chk({name, "_hold_done"}, 64'(done), 64'(1));
            chk({name, "_hold_result"}, result, e.res);
        end
        last_exp = e.res;
        ovr = 1'b1;
        @(negedge clk);
        ovr = 1'b0; in_valid = 1'b0;
        #1;
        chk({name, "_idle_after"}, {61'b0, done, busy, okp}, 64'b001);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; is_word = 1'b0; flush = 1'b0; ovr = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {result, 61'b0, done, busy, okp}, {64'b0, 64'b001});
        rst = 1'b0;
        @(negedge clk);
        chk("idle_state", {61'b0, done, busy, okp}, 64'b001);

        run_op(3'd5, 1'b0, 64'd100, 64'd7, 0, "divu");
        run_op(3'd7, 1'b0, 64'd100, 64'd7, 1, "remu");
        run_op(3'd4, 1'b0, 64'd5, 64'd0, 0, "div_by_zero");
        run_op(3'd6, 1'b0, 64'd5, 64'd0, 0, "rem_by_zero");
        run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0, "div_ovf");
        run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 0, "rem_ovf");
        run_op(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 0, "mul");
        run_op(3'd1, 1'b0, '1, '1, 0, "mulh");
        run_op(3'd3, 1'b0, '1, '1, 0, "mulhu");
        run_op(3'd2, 1'b0, '1, '1, 0, "mulhsu");
        run_op(3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, "divw_ovf");
        run_op(3'd5, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 0, "divuw");
        run_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, "rem_neg");
        run_op(3'd5, 1'b0, 64'd1000, 64'd9, 5, "stall5");

        // flush mid-iteration, then a new op in the first idle cycle
        funct3 = 3'd5; is_word = 1'b0; op_a = 64'd100; op_b = 64'd7; in_valid = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {61'b0, done, busy, 1'b0}, 64'b000);
        chk("flush_result_kept", result, last_exp);
        run_op(3'd0, 1'b0, 64'd123456789, 64'hFFFF_FFFF_FFFF_FF00, 0, "mul_after_flush");

        // flush and in_valid together in idle: nothing accepted
        funct3 = 3'd5; op_a = 64'd100; op_b = 64'd7; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_vs_valid", {62'b0, done, busy}, 64'b0);
        @(negedge clk);
        chk("flush_vs_valid_later", {62'b0, done, busy}, 64'b0);

        // reset while iterating
        funct3 = 3'd5; op_a = 64'd100; op_b = 64'd7; in_valid = 1'b1;
        exp_q.push_back('{res: 64'd14, lat: 65, name: "divu_reset"});
        accept_cyc = cyc;
        repeat (20) @(negedge clk);
        chk("busy_before_reset", 64'(busy), 64'(1));
        rst = 1'b1; in_valid = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("reset_mid_busy", {result, 62'b0, done, busy}, 128'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            logic [2:0] f;
            logic       w;
            f = 3'($urandom);
            w = 1'($urandom);
            if (w && !f[2]) f = 3'd0;
            run_op(f, w, rnd_op(), rnd_op(), $urandom_range(0, 2), $sformatf("rnd%0d_f%0d_w%0d", i, f, w));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
